// File: rtl/wb_pkg.sv
// Shared Wishbone constants, arbiter modes and state encoding for the system-bus arbiter.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int MODE_RR   = 0;
    localparam int MODE_PRIO = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Never returns less than 1 so single-entry indices still have a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating priority encoder: searches req upward from last+1 with wrap, or from index 0
// in fixed-priority mode.
module wb_rr_pick
    import wb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    input  logic             mode,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    always_comb begin
        int base;
        int idx;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        // Fixed priority is the rotating search pinned to last = N-1.
        base   = mode ? (N - 1) : int'(last);
        for (int k = 1; k <= N; k++) begin
            idx = (base + k) % N;
            if (!any && req[IDX_W'(idx)]) begin
                any    = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter with round-robin or fixed-priority grant,
// ownership held until the owner drops cyc, and an optional stall watchdog.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int ADR_W     = 30,
    parameter  int DAT_W     = 32,
    parameter  int MODE      = 0,
    parameter  int TIMEOUT   = 0,
    localparam int SEL_W     = DAT_W / 8
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [N_MASTERS-1:0]         m_cyc_i,
    input  logic [N_MASTERS-1:0]         m_stb_i,
    input  logic [N_MASTERS-1:0]         m_we_i,
    input  logic [N_MASTERS*ADR_W-1:0]   m_adr_i,
    input  logic [N_MASTERS*DAT_W-1:0]   m_dat_i,
    input  logic [N_MASTERS*SEL_W-1:0]   m_sel_i,
    input  logic [N_MASTERS*3-1:0]       m_cti_i,
    input  logic [N_MASTERS*2-1:0]       m_bte_i,
    output logic [DAT_W-1:0]             m_dat_o,
    output logic [N_MASTERS-1:0]         m_ack_o,
    output logic [N_MASTERS-1:0]         m_err_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic [ADR_W-1:0]             s_adr_o,
    output logic [DAT_W-1:0]             s_dat_o,
    output logic [SEL_W-1:0]             s_sel_o,
    output logic [2:0]                   s_cti_o,
    output logic [1:0]                   s_bte_o,
    input  logic [DAT_W-1:0]             s_dat_i,
    input  logic                         s_ack_i,
    input  logic                         s_err_i
);

    localparam int IDX_W   = clog2(N_MASTERS);
    localparam int WD_W    = clog2(TIMEOUT + 1);
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;

    logic             owner_valid;
    logic             pick_any;
    logic [IDX_W-1:0] pick_winner;
    logic             stall;
    logic             wd_err;
    int               own;

    assign owner_valid = (state_q == ST_GRANT);
    assign own         = int'(owner_q);

    wb_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (m_cyc_i),
        .last   (last_q),
        .mode   (MODE == MODE_PRIO),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Payload follows the owner register even when no grant is active.
    always_comb begin
        s_cyc_o = owner_valid & m_cyc_i[owner_q];
        s_stb_o = s_cyc_o & m_stb_i[owner_q];
        s_we_o  = m_we_i[owner_q];
        s_adr_o = m_adr_i[own*ADR_W +: ADR_W];
        s_dat_o = m_dat_i[own*DAT_W +: DAT_W];
        s_sel_o = m_sel_i[own*SEL_W +: SEL_W];
        s_cti_o = m_cti_i[own*3 +: 3];
        s_bte_o = m_bte_i[own*2 +: 2];
        m_dat_o = s_dat_i;
    end

    // A concurrent ack removes the stall, so ack always beats a watchdog expiry.
    always_comb begin
        stall    = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
        wd_err   = (TIMEOUT > 0) && stall && (wd_cnt_q == WD_W'(WD_LAST));
        wd_cnt_d = ((TIMEOUT > 0) && stall && !wd_err) ? wd_cnt_q + 1'b1 : '0;
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (owner_valid) begin
            m_ack_o[owner_q] = s_ack_i;
            m_err_o[owner_q] = s_err_i | wd_err;
        end
    end

    // The owner's own cyc is low whenever re-arbitration runs, so it never re-wins itself.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    owner_d = pick_winner;
                    last_d  = pick_winner;
                end
            end
            ST_GRANT: begin
                if (!m_cyc_i[owner_q]) begin
                    if (pick_any) begin
                        owner_d = pick_winner;
                        last_d  = pick_winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            last_q   <= LAST_RST;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: a round-robin/watchdog instance and a fixed-priority instance
// share stimulus and are compared every cycle against a transaction-level reference.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  cyc = '0, stb = '0, we = '0;
    logic [N*AW-1:0] adr = '0;
    logic [N*DW-1:0] dat = '0;
    logic [N*4-1:0]  sel = '0;
    logic [N*3-1:0]  cti = '0;
    logic [N*2-1:0]  bte = '0;
    logic [DW-1:0] s_dat = '0;
    logic          s_ack = 1'b0, s_err = 1'b0;

    logic          o_cyc[2], o_stb[2], o_we[2];
    logic [AW-1:0] o_adr[2];
    logic [DW-1:0] o_sdat[2], o_mdat[2];
    logic [3:0]    o_sel[2];
    logic [2:0]    o_cti[2];
    logic [1:0]    o_bte[2];
    logic [N-1:0]  o_ack[2], o_err[2];

    always #5 clk = ~clk;

    wb_rr_arbiter #(.N_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .MODE(0), .TIMEOUT(8)) u_rr (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(adr), .m_dat_i(dat),
        .m_sel_i(sel), .m_cti_i(cti), .m_bte_i(bte),
        .m_dat_o(o_mdat[0]), .m_ack_o(o_ack[0]), .m_err_o(o_err[0]),
        .s_cyc_o(o_cyc[0]), .s_stb_o(o_stb[0]), .s_we_o(o_we[0]), .s_adr_o(o_adr[0]),
        .s_dat_o(o_sdat[0]), .s_sel_o(o_sel[0]), .s_cti_o(o_cti[0]), .s_bte_o(o_bte[0]),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    wb_rr_arbiter #(.N_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .MODE(1), .TIMEOUT(0)) u_pr (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(adr), .m_dat_i(dat),
        .m_sel_i(sel), .m_cti_i(cti), .m_bte_i(bte),
        .m_dat_o(o_mdat[1]), .m_ack_o(o_ack[1]), .m_err_o(o_err[1]),
        .s_cyc_o(o_cyc[1]), .s_stb_o(o_stb[1]), .s_we_o(o_we[1]), .s_adr_o(o_adr[1]),
        .s_dat_o(o_sdat[1]), .s_sel_o(o_sel[1]), .s_cti_o(o_cti[1]), .s_bte_o(o_bte[1]),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference: who owns the bus, who was granted last, how long the owner has stalled.
    bit mv[2];
    int mo[2], ml[2], mw[2];
    bit e_stall[2], e_wde[2];
    int mode_of[2] = '{0, 1};
    int to_of[2]   = '{8, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int d);
        if (mode_of[d] == 1) begin
            for (int i = 0; i < N; i++) if (cyc[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (cyc[(ml[d] + k) % N]) return (ml[d] + k) % N;
        end
        return -1;
    endfunction

    task automatic check_dut(input int d);
        int o;
        string p;
        logic ecyc, estb;
        logic [N-1:0] eack, eerr;
        o = mo[d];
        p = (d == 0) ? "rr" : "pr";
        ecyc = mv[d] && cyc[o];
        estb = ecyc && stb[o];
        e_stall[d] = estb && !s_ack && !s_err;
        e_wde[d] = (to_of[d] > 0) && e_stall[d] && (mw[d] == to_of[d] - 1);
        eack = '0;
        eerr = '0;
        if (mv[d]) begin
            eack[o] = s_ack;
            eerr[o] = s_err || e_wde[d];
        end
        check({p, ".cyc"}, 64'(o_cyc[d]), 64'(ecyc));
        check({p, ".stb"}, 64'(o_stb[d]), 64'(estb));
        check({p, ".we"},  64'(o_we[d]),  64'(we[o]));
        check({p, ".adr"}, 64'(o_adr[d]), 64'(adr[o*AW +: AW]));
        check({p, ".sdat"}, 64'(o_sdat[d]), 64'(dat[o*DW +: DW]));
        check({p, ".sel"}, 64'(o_sel[d]), 64'(sel[o*4 +: 4]));
        check({p, ".cti"}, 64'(o_cti[d]), 64'(cti[o*3 +: 3]));
        check({p, ".bte"}, 64'(o_bte[d]), 64'(bte[o*2 +: 2]));
        check({p, ".mdat"}, 64'(o_mdat[d]), 64'(s_dat));
        check({p, ".ack"}, 64'(o_ack[d]), 64'(eack));
        check({p, ".err"}, 64'(o_err[d]), 64'(eerr));
    endtask

    task automatic advance(input int d);
        int w;
        if (!mv[d] || !cyc[mo[d]]) begin
            w = pick(d);
            if (w >= 0) begin
                mv[d] = 1'b1;
                mo[d] = w;
                ml[d] = w;
            end else begin
                mv[d] = 1'b0;
            end
        end
        mw[d] = (e_stall[d] && !e_wde[d]) ? mw[d] + 1 : 0;
    endtask

    // Call #1 after inputs change; checks this cycle, then moves the model past the edge.
    task automatic step();
        for (int d = 0; d < 2; d++) check_dut(d);
        for (int d = 0; d < 2; d++) advance(d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mo[d] = 0; ml[d] = N - 1; mw[d] = 0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst.cyc", 64'(o_cyc[d]), 64'(0));
            check("rst.stb", 64'(o_stb[d]), 64'(0));
            check("rst.ack", 64'(o_ack[d]), 64'(0));
            check("rst.err", 64'(o_err[d]), 64'(0));
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic payload();
        for (int i = 0; i < N; i++) begin
            adr[i*AW +: AW] = AW'($urandom);
            dat[i*DW +: DW] = $urandom;
        end
        sel   = 16'($urandom);
        bte   = 8'($urandom);
        we    = 4'($urandom);
        s_dat = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int ack_pct;
        cyc = 4'hF; s_ack = 1'b1;
        do_reset();

        // Single read by master 0.
        cyc = 4'b0001; stb = 4'b0001; s_ack = 1'b0; cti = '0; payload(); #1;
        check("t1.no_early_cyc", 64'(o_cyc[0]), 64'(0));
        step();
        s_ack = 1'b1; #1;
        check("t1.cyc", 64'(o_cyc[0]), 64'(1));
        check("t1.ack", 64'(o_ack[0]), 64'(4'b0001));
        step();
        cyc = '0; stb = '0; s_ack = 1'b0; #1; step();

        // All four request; each owner takes one acked cycle then drops cyc.
        do_reset();
        cyc = 4'hF; stb = 4'hF; payload(); #1; step();
        for (int k = 0; k < 5; k++) begin
            cyc = 4'hF; s_ack = 1'b1; payload(); #1;
            check("t2.grant_order", 64'(o_ack[0]), 64'(1 << (k % N)));
            step();
            cyc = 4'hF & ~(4'(1) << (k % N)); s_ack = 1'b0; #1;
            check("t2.owner_dropped", 64'(o_cyc[0]), 64'(0));
            step();
        end

        // Masters 1 and 3 cycle cyc together; fixed priority always serves master 1.
        cyc = '0; stb = '0; #1; step();
        for (int r = 0; r < 4; r++) begin
            cyc = 4'b1010; stb = 4'b1010; s_ack = 1'b0; #1; step();
            s_ack = 1'b1; #1;
            check("t3.prio_m1", 64'(o_ack[1]), 64'(4'b0010));
            step();
            cyc = '0; s_ack = 1'b0; #1; step();
        end

        // 4-beat INCR burst from master 0 while master 1 waits.
        do_reset();
        cyc = 4'b0011; stb = 4'b0011; s_ack = 1'b0; cti = '0; cti[2:0] = 3'b010; #1; step();
        for (int b = 0; b < 4; b++) begin
            cti[2:0] = (b < 3) ? 3'b010 : 3'b111; s_ack = 1'b1; payload(); #1;
            check("t4.burst_ack", 64'(o_ack[0]), 64'(4'b0001));
            check("t4.burst_cti", 64'(o_cti[0]), 64'(cti[2:0]));
            step();
        end
        cyc = 4'b0010; stb = 4'b0010; s_ack = 1'b0; #1; step();
        s_ack = 1'b1; #1;
        check("t4.m1_after", 64'(o_ack[0]), 64'(4'b0010));
        step();

        // Watchdog: err on the 8th stalled cycle, once; ack on that cycle wins.
        do_reset();
        cyc = 4'b0001; stb = 4'b0001; s_ack = 1'b0; #1; step();
        for (int j = 1; j <= 10; j++) begin
            #1;
            check("t5.wd_err", 64'(o_err[0]), 64'((j == 8) ? 4'b0001 : 4'b0000));
            check("t5.no_wd", 64'(o_err[1]), 64'(0));
            step();
        end
        cyc = '0; #1; step();
        cyc = 4'b0001; #1; step();
        for (int j = 1; j <= 8; j++) begin
            s_ack = (j == 8); #1;
            if (j == 8) begin
                check("t5.ack_wins", 64'(o_ack[0]), 64'(4'b0001));
                check("t5.ack_no_err", 64'(o_err[0]), 64'(0));
            end
            step();
        end

        // Reset in the middle of a burst.
        do_reset();
        cyc = 4'b0011; stb = 4'b0011; s_ack = 1'b0; cti[2:0] = 3'b010; #1; step();
        s_ack = 1'b1; #1; step();
        #1;
        check("t6.busy", 64'(o_cyc[0]), 64'(1));
        #1;
        do_reset();
        s_ack = 1'b0; #1; step();
        s_ack = 1'b1; #1;
        check("t6.rr_first", 64'(o_ack[0]), 64'(4'b0001));
        check("t6.pr_first", 64'(o_ack[1]), 64'(4'b0001));
        step();

        // Randomized traffic with slow and fast slave phases.
        ack_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) ack_pct = (ack_pct == 50) ? 5 : 50;
            for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) cyc[i] = ~cyc[i];
            stb   = 4'($urandom) | 4'($urandom);
            cti   = 12'($urandom);
            s_ack = ($urandom_range(99) < ack_pct);
            s_err = ($urandom_range(31) == 0);
            payload();
            #1;
            if (c % 1000 == 999) begin
                #1;
                do_reset();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
